cpu_obi_demux: RTL and testbench
================================

Name: cpu_obi_demux

Overview:
- Per-core private OBI demultiplexer between one core's data port and two targets: the system-bus master port (BUS_SYSTEM_IDX) and the core-local register block (CPU_REG_IDX).
- Decodes each request against the CPU private address map and tracks outstanding transactions so responses return in order.
- Terminates unmapped accesses with an internal error responder.
- One instance per core; sits directly downstream of the core data port and upstream of the system crossbar master ports CORE*_DATA_IDX.

Parameters:
- MAX_OUTSTANDING, 4, maximum in-flight (granted, not yet responded) transactions, ≥1.
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- core_req_i  in  1  OBI request from core
- core_gnt_o  out  1  OBI grant to core
- core_addr_i  in  32  byte address
- core_we_i  in  1  write enable
- core_be_i  in  4  byte enables
- core_wdata_i  in  32  write data
- core_rvalid_o  out  1  response valid
- core_rdata_o  out  32  read data
- core_err_o  out  1  decode error, qualified by core_rvalid_o
- sys_req_o / sys_gnt_i / sys_addr_o[32] / sys_we_o / sys_be_o[4] / sys_wdata_o[32] / sys_rvalid_i / sys_rdata_i[32]  system-bus OBI port
- reg_req_o / reg_gnt_i / reg_addr_o[32] / reg_we_o / reg_be_o[4] / reg_wdata_o[32] / reg_rvalid_i / reg_rdata_i[32]  CPU register OBI port

Behaviour:
- Clock clk_i; reset synchronous, active-low on rst_ni (sampled on rising edge only).
- Decode (combinational, half-open ranges):
  - REG if 0xFF000000 ≤ addr < 0xFF001000.
  - SYS if 0xF0010000 ≤ addr < 0xFF000000, or addr < 0x41000000.
  - ERR otherwise.
  - Compare in 33 bits; end addresses do not wrap.
- addr/we/be/wdata are broadcast to both ports unmodified; only req is steered.
- State: cnt[CNT_W] outstanding count; tgt[2] target of in-flight transactions (SYS=0, REG=1, ERR=2); err_pend 1 bit.
- Accept condition, with t = decoded target: allow = (cnt==0 || t==tgt) && cnt<MAX_OUTSTANDING.
  - No same-cycle bypass: a response arriving this cycle does not free a slot or permit a target switch until the next cycle.
- sys_req_o = core_req_i & allow & t==SYS; reg_req_o likewise for REG.
- core_gnt_o:
  - sys_gnt_i when t==SYS.
  - reg_gnt_i when t==REG.
  - 1 when t==ERR & allow.
  - 0 otherwise.
- On handshake (core_req_i & core_gnt_o): tgt<=t.
- ERR handshake: err_pend<=1 on next edge; response issued in that cycle (1-cycle latency).
  - Back-to-back ERR grants yield back-to-back responses.
- Response select uses registered tgt:
  - SYS: core_rvalid_o=sys_rvalid_i, core_rdata_o=sys_rdata_i, core_err_o=0.
  - REG: core_rvalid_o=reg_rvalid_i, core_rdata_o=reg_rdata_i, core_err_o=0.
  - ERR: core_rvalid_o=err_pend, core_rdata_o=32'hBADACCE5, core_err_o=err_pend.
- cnt update: +1 on handshake, −1 on core_rvalid_o, unchanged when both occur in the same cycle.
- rvalid with cnt==0 (slave protocol violation): ignored, cnt does not underflow, core_rvalid_o forced 0.
- Reset values: cnt=0, tgt=SYS, err_pend=0.
  - All *_req_o=0, core_gnt_o=0, core_rvalid_o=0, core_err_o=0, core_rdata_o=0.
  - Reset during in-flight transactions discards tracking; late slave responses after reset are dropped per the cnt==0 rule.
- Core holds req/addr stable until gnt (OBI); the demux never asserts a slave req it will not forward a gnt from.

Decomposition:
- cei_mochila_pkg gains:
  - CPU_PRIV_TGT_SYS/REG/ERR target encodings.
  - CPU_ERR_RDATA = 32'hBADACCE5 (reuse of ERROR_START_ADDRESS value).
  - Decode range constants derived from the existing BUS_SYSTEM, EXT_BUS_SYSTEM and CPU_REG constants.
- One sub-module: cpu_obi_err_resp (err_pend register plus response generation).
- Decode stays inline.

Test Plan:
- Read 0xFF000010, reg_gnt_i same cycle, reg_rvalid_i+2 cycles with 0x12345678 -> reg_req_o=1, sys_req_o=0; core_rdata_o=0x12345678; cnt returns to 0.
- Four back-to-back SYS reads to 0xF0100000.., sys_gnt_i=1, no rvalid -> 4 grants; 5th request gets core_gnt_o=0 until first sys_rvalid_i, then granted the following cycle.
- SYS read outstanding (cnt=1), then request to 0xFF000004 -> reg_req_o=0, core_gnt_o=0 until SYS response retires; REG granted on the next cycle.
- Read 0x80000000 -> core_gnt_o=1 immediately, next cycle core_rvalid_o=1, core_err_o=1, core_rdata_o=0xBADACCE5; no slave req asserted.
- Boundary decode: 0x40FFFFFC->SYS, 0x41000000->ERR, 0xFEFFFFFC->SYS, 0xFF001000->ERR.
- rst_ni low for one cycle with cnt=2, then spurious sys_rvalid_i -> cnt=0, core_rvalid_o=0, all outputs at reset values.

Source files
------------

// File: rtl/cei_mochila_pkg.sv
// rtl/cei_mochila_pkg.sv - shared address map, target encodings and CPU private decode constants
package cei_mochila_pkg;

  // System address map
  localparam logic [31:0] EXT_BUS_SYSTEM_START_ADDRESS = 32'h0000_0000;
  localparam logic [31:0] EXT_BUS_SYSTEM_END_ADDRESS   = 32'h4100_0000;
  localparam logic [31:0] BUS_SYSTEM_START_ADDRESS     = 32'hF001_0000;
  localparam logic [31:0] BUS_SYSTEM_END_ADDRESS       = 32'hFF00_0000;
  localparam logic [31:0] CPU_REG_START_ADDRESS        = 32'hFF00_0000;
  localparam logic [31:0] CPU_REG_SIZE                 = 32'h0000_1000;
  localparam logic [31:0] ERROR_START_ADDRESS          = 32'hBADA_CCE5;

  // Target of the in-flight transactions of one core data port
  typedef enum logic [1:0] {
    CPU_PRIV_TGT_SYS = 2'd0,
    CPU_PRIV_TGT_REG = 2'd1,
    CPU_PRIV_TGT_ERR = 2'd2
  } cpu_priv_tgt_e;

  // Read data returned for accesses that hit no target
  localparam logic [31:0] CPU_ERR_RDATA = ERROR_START_ADDRESS;

  // Decode bounds widened to 33 bits so end addresses never wrap
  localparam logic [32:0] CPU_DEC_REG_START = {1'b0, CPU_REG_START_ADDRESS};
  localparam logic [32:0] CPU_DEC_REG_END   = {1'b0, CPU_REG_START_ADDRESS} + {1'b0, CPU_REG_SIZE};
  localparam logic [32:0] CPU_DEC_SYS_START = {1'b0, BUS_SYSTEM_START_ADDRESS};
  localparam logic [32:0] CPU_DEC_SYS_END   = {1'b0, BUS_SYSTEM_END_ADDRESS};
  localparam logic [32:0] CPU_DEC_EXT_END   = {1'b0, EXT_BUS_SYSTEM_END_ADDRESS};

endpackage

// File: rtl/cpu_obi_err_resp.sv
// rtl/cpu_obi_err_resp.sv - one-cycle error responder for unmapped core accesses
module cpu_obi_err_resp
  import cei_mochila_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        err_hs_i,
  output logic        err_pend_o,
  output logic [31:0] err_rdata_o
);

  logic err_pend_d;
  logic err_pend_q;

  // Every accepted unmapped access answers on the following cycle
  always_comb begin
    err_pend_d = err_hs_i;
  end

  // Pending-response register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_pend_q <= 1'b0;
    end else begin
      err_pend_q <= err_pend_d;
    end
  end

  assign err_pend_o  = err_pend_q;
  assign err_rdata_o = CPU_ERR_RDATA;

endmodule

// File: rtl/cpu_obi_demux.sv
// rtl/cpu_obi_demux.sv - per-core OBI demux to system bus, CPU registers and error responder
module cpu_obi_demux
  import cei_mochila_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        sys_req_o,
  input  logic        sys_gnt_i,
  output logic [31:0] sys_addr_o,
  output logic        sys_we_o,
  output logic [3:0]  sys_be_o,
  output logic [31:0] sys_wdata_o,
  input  logic        sys_rvalid_i,
  input  logic [31:0] sys_rdata_i,
  output logic        reg_req_o,
  input  logic        reg_gnt_i,
  output logic [31:0] reg_addr_o,
  output logic        reg_we_o,
  output logic [3:0]  reg_be_o,
  output logic [31:0] reg_wdata_o,
  input  logic        reg_rvalid_i,
  input  logic [31:0] reg_rdata_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cpu_priv_tgt_e    tgt_dec;
  cpu_priv_tgt_e    tgt_d, tgt_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [32:0]      addr33;
  logic             allow;
  logic             handshake;
  logic             err_hs;
  logic             err_pend;
  logic [31:0]      err_rdata;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;

  assign addr33 = {1'b0, core_addr_i};

  // Address decode against the CPU private map
  always_comb begin
    tgt_dec = CPU_PRIV_TGT_ERR;
    if (addr33 >= CPU_DEC_REG_START && addr33 < CPU_DEC_REG_END) begin
      tgt_dec = CPU_PRIV_TGT_REG;
    end else if ((addr33 >= CPU_DEC_SYS_START && addr33 < CPU_DEC_SYS_END) ||
                 addr33 < CPU_DEC_EXT_END) begin
      tgt_dec = CPU_PRIV_TGT_SYS;
    end
  end

  // Request steering and grant return; a target switch waits for the pipe to drain
  always_comb begin
    allow      = rst_ni && (cnt_q == '0 || tgt_dec == tgt_q) && cnt_q < CNT_MAX;
    sys_req_o  = core_req_i && allow && tgt_dec == CPU_PRIV_TGT_SYS;
    reg_req_o  = core_req_i && allow && tgt_dec == CPU_PRIV_TGT_REG;
    core_gnt_o = 1'b0;
    case (tgt_dec)
      CPU_PRIV_TGT_SYS: core_gnt_o = sys_gnt_i && allow;
      CPU_PRIV_TGT_REG: core_gnt_o = reg_gnt_i && allow;
      default:          core_gnt_o = allow;
    endcase
    handshake = core_req_i && core_gnt_o;
    err_hs    = handshake && tgt_dec == CPU_PRIV_TGT_ERR;
  end

  assign sys_addr_o  = core_addr_i;
  assign sys_we_o    = core_we_i;
  assign sys_be_o    = core_be_i;
  assign sys_wdata_o = core_wdata_i;
  assign reg_addr_o  = core_addr_i;
  assign reg_we_o    = core_we_i;
  assign reg_be_o    = core_be_i;
  assign reg_wdata_o = core_wdata_i;

  cpu_obi_err_resp u_err_resp (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .err_hs_i    (err_hs),
    .err_pend_o  (err_pend),
    .err_rdata_o (err_rdata)
  );

  // Response select by registered target; responses with nothing in flight are dropped
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    case (tgt_q)
      CPU_PRIV_TGT_SYS: begin rsp_valid = sys_rvalid_i; rsp_rdata = sys_rdata_i; end
      CPU_PRIV_TGT_REG: begin rsp_valid = reg_rvalid_i; rsp_rdata = reg_rdata_i; end
      default:          begin rsp_valid = err_pend;     rsp_rdata = err_rdata;   end
    endcase
    core_rvalid_o = rst_ni && rsp_valid && cnt_q != '0;
    core_rdata_o  = core_rvalid_o ? rsp_rdata : '0;
    core_err_o    = core_rvalid_o && tgt_q == CPU_PRIV_TGT_ERR;
  end

  // Next-state for the outstanding counter and in-flight target
  always_comb begin
    tgt_d = handshake ? tgt_dec : tgt_q;
    cnt_d = cnt_q;
    if (handshake && !core_rvalid_o) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!handshake && core_rvalid_o) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Tracking state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tgt_q <= CPU_PRIV_TGT_SYS;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end

endmodule

// File: tb/tb_cpu_obi_demux.sv
// tb/tb_cpu_obi_demux.sv - randomized self-checking bench for cpu_obi_demux
module tb_cpu_obi_demux;

  localparam int MAXO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_gnt_o, core_we_i, core_rvalid_o, core_err_o;
  logic [31:0] core_addr_i, core_wdata_i, core_rdata_o;
  logic [3:0]  core_be_i;
  logic        sys_req_o, sys_gnt_i, sys_we_o, sys_rvalid_i;
  logic [31:0] sys_addr_o, sys_wdata_o, sys_rdata_i;
  logic [3:0]  sys_be_o;
  logic        reg_req_o, reg_gnt_i, reg_we_o, reg_rvalid_i;
  logic [31:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic [3:0]  reg_be_o;

  always #5 clk_i = ~clk_i;

  cpu_obi_demux #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_addr_i(core_addr_i),
    .core_we_i(core_we_i), .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .sys_req_o(sys_req_o), .sys_gnt_i(sys_gnt_i), .sys_addr_o(sys_addr_o),
    .sys_we_o(sys_we_o), .sys_be_o(sys_be_o), .sys_wdata_o(sys_wdata_o),
    .sys_rvalid_i(sys_rvalid_i), .sys_rdata_i(sys_rdata_i),
    .reg_req_o(reg_req_o), .reg_gnt_i(reg_gnt_i), .reg_addr_o(reg_addr_o),
    .reg_we_o(reg_we_o), .reg_be_o(reg_be_o), .reg_wdata_o(reg_wdata_o),
    .reg_rvalid_i(reg_rvalid_i), .reg_rdata_i(reg_rdata_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Reference model: 0 = system bus, 1 = CPU registers, 2 = error
  function automatic int decode(input logic [31:0] a);
    if (a >= 32'hFF00_0000 && a < 32'hFF00_1000) return 1;
    if ((a >= 32'hF001_0000 && a < 32'hFF00_0000) || a < 32'h4100_0000) return 0;
    return 2;
  endfunction

  logic [31:0] addr_tbl [12] = '{
    32'hFF00_0010, 32'hFF00_0FFC, 32'hFF00_1000, 32'hF010_0000,
    32'hF001_0000, 32'hF000_FFFC, 32'h40FF_FFFC, 32'h4100_0000,
    32'hFEFF_FFFC, 32'h8000_0000, 32'h0000_0000, 32'hFF00_0004
  };

  int  q_tgt[$];
  bit  err_prev, holding, spur;
  int  sys_pend, reg_pend;
  int  t, n, cur;
  bit  allow, exp_gnt, exp_rv, hs;
  logic [31:0] exp_rdata;

  initial begin
    rst_ni = 1'b0;
    core_req_i = 1'b0; core_addr_i = '0; core_we_i = 1'b0; core_be_i = '0; core_wdata_i = '0;
    sys_gnt_i = 1'b0; sys_rvalid_i = 1'b0; sys_rdata_i = '0;
    reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0; reg_rdata_i = '0;
    err_prev = 0; holding = 0; spur = 0; sys_pend = 0; reg_pend = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk_i);
      #1;
      rst_ni = !(cyc < 2 || cyc == 1500 || cyc == 2800);
      if (!rst_ni) begin
        core_req_i  = 1'($urandom_range(0, 1));
        core_addr_i = addr_tbl[$urandom_range(0, 11)];
      end else if (!holding) begin
        core_req_i  = ($urandom_range(0, 3) != 0);
        core_addr_i = ($urandom_range(0, 5) == 0) ? $urandom : addr_tbl[$urandom_range(0, 11)];
        core_we_i   = 1'($urandom_range(0, 1));
        core_be_i   = 4'($urandom);
        core_wdata_i = $urandom;
      end
      sys_gnt_i = ($urandom_range(0, 2) != 0);
      reg_gnt_i = ($urandom_range(0, 2) != 0);
      if (!rst_ni || spur) begin
        sys_rvalid_i = 1'b1;
        reg_rvalid_i = 1'b1;
      end else begin
        sys_rvalid_i = (sys_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        reg_rvalid_i = (reg_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      end
      sys_rdata_i = $urandom;
      reg_rdata_i = $urandom;

      @(negedge clk_i);
      t   = decode(core_addr_i);
      n   = q_tgt.size();
      cur = (n > 0) ? q_tgt[0] : 0;
      allow = rst_ni && (n == 0 || t == q_tgt[n-1]) && n < MAXO;
      exp_gnt = allow && ((t == 0) ? sys_gnt_i : (t == 1) ? reg_gnt_i : 1'b1);
      exp_rv = rst_ni && n > 0 &&
               ((cur == 0) ? sys_rvalid_i : (cur == 1) ? reg_rvalid_i : err_prev);
      exp_rdata = !exp_rv ? 32'h0 : (cur == 0) ? sys_rdata_i : (cur == 1) ? reg_rdata_i : 32'hBADACCE5;

      check_eq("sys_req", 32'(sys_req_o), 32'(core_req_i && allow && t == 0));
      check_eq("reg_req", 32'(reg_req_o), 32'(core_req_i && allow && t == 1));
      check_eq("core_gnt", 32'(core_gnt_o), 32'(exp_gnt));
      check_eq("core_rvalid", 32'(core_rvalid_o), 32'(exp_rv));
      check_eq("core_err", 32'(core_err_o), 32'(exp_rv && cur == 2));
      check_eq("core_rdata", core_rdata_o, exp_rdata);
      check_eq("sys_addr", sys_addr_o, core_addr_i);
      check_eq("reg_wdata", reg_wdata_o, core_wdata_i);
      check_eq("reg_be", 32'(reg_be_o), 32'(core_be_i));

      if (!rst_ni) begin
        q_tgt.delete();
        err_prev = 0; holding = 0; sys_pend = 0; reg_pend = 0; spur = 1;
      end else begin
        hs = core_req_i && exp_gnt;
        if (exp_rv) void'(q_tgt.pop_front());
        if (hs) q_tgt.push_back(t);
        if (sys_rvalid_i && sys_pend > 0) sys_pend--;
        if (reg_rvalid_i && reg_pend > 0) reg_pend--;
        if (hs && t == 0) sys_pend++;
        if (hs && t == 1) reg_pend++;
        err_prev = hs && t == 2;
        holding  = core_req_i && !exp_gnt;
        spur = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
